// File: rtl/tama_pkg.sv
// Shared types and constants for the pet event path.
package tama_pkg;

  localparam int unsigned RAND_W = 8;
  localparam int unsigned KIND_W = 2;
  localparam int unsigned WAIT_W = 9;
  localparam int unsigned LATE_W = 4;

  localparam logic [LATE_W-1:0] LATE_MAX = LATE_W'(15);

  // Event kinds delivered to the pet status/animation controller.
  typedef enum logic [KIND_W-1:0] {
    EV_HUNGER = 2'd0,
    EV_BORED  = 2'd1,
    EV_SICK   = 2'd2,
    EV_SLEEPY = 2'd3
  } event_kind_e;

  // Scheduler control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FIRE = 2'd3
  } sched_state_e;

  // Kind constants consumed by the pet controller.
  localparam event_kind_e KIND_HUNGER = EV_HUNGER;
  localparam event_kind_e KIND_BORED  = EV_BORED;
  localparam event_kind_e KIND_SICK   = EV_SICK;
  localparam event_kind_e KIND_SLEEPY = EV_SLEEPY;

  // Wait length: minimum plus masked random extra, zero-extended so it never wraps.
  function automatic logic [WAIT_W-1:0] wait_load(input logic [RAND_W-1:0] min_wait,
                                                  input logic [RAND_W-1:0] mask,
                                                  input logic [RAND_W-1:0] rnd);
    return WAIT_W'(min_wait) + WAIT_W'(rnd & mask);
  endfunction

  // Event kind comes from the two top bits of the random byte.
  function automatic event_kind_e kind_of(input logic [RAND_W-1:0] rnd);
    return event_kind_e'(rnd[RAND_W-1 -: KIND_W]);
  endfunction

endpackage

// File: rtl/sched_countdown.sv
// Loadable tick-driven down-counter with clear and terminal-tick flag.
module sched_countdown
  import tama_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              clear,
  output logic [WAIT_W-1:0] count,
  output logic              terminal_c
);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  // Clear beats load beats decrement; the count stops at zero.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick_en && (count_q != '0)) begin
      count_d = count_q - WAIT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign terminal_c = tick_en && (count_q == WAIT_W'(1));

endmodule

// File: rtl/event_scheduler.sv
// Turns random bytes into timed pet events offered over valid/ready.
module event_scheduler
  import tama_pkg::*;
#(
  parameter int unsigned         MIN_WAIT  = 8,
  parameter logic [RAND_W-1:0]   RAND_MASK = 8'h3F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              enable,
  input  logic [RAND_W-1:0] rand_in,
  output logic              event_valid,
  output logic [KIND_W-1:0] event_kind,
  input  logic              event_ready,
  output logic [WAIT_W-1:0] wait_left,
  output logic [LATE_W-1:0] late_ticks
);

  sched_state_e      state_q, state_d;
  logic              event_valid_q, event_valid_d;
  event_kind_e       event_kind_q, event_kind_d;
  logic [LATE_W-1:0] late_ticks_q, late_ticks_d;

  logic              cnt_load;
  logic              cnt_clear;
  logic [WAIT_W-1:0] cnt_load_val;
  logic [WAIT_W-1:0] cnt_count;
  logic              cnt_term_c;

  // Wait countdown; raw tick is safe because the count is only nonzero in WAIT.
  sched_countdown u_countdown (
    .clk        (clk),
    .rst        (rst),
    .tick_en    (tick),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .clear      (cnt_clear),
    .count      (cnt_count),
    .terminal_c (cnt_term_c)
  );

  // Next-state, event latch and lateness counter.
  always_comb begin
    state_d       = state_q;
    event_valid_d = event_valid_q;
    event_kind_d  = event_kind_q;
    late_ticks_d  = late_ticks_q;
    cnt_load      = 1'b0;
    cnt_clear     = 1'b0;
    cnt_load_val  = wait_load(RAND_W'(MIN_WAIT), RAND_MASK, rand_in);

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ARM;
        end
      end

      ST_ARM: begin
        if (enable) begin
          cnt_load     = 1'b1;
          late_ticks_d = '0;
          state_d      = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (!enable) begin
          cnt_clear = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_term_c) begin
          event_kind_d  = kind_of(rand_in);
          event_valid_d = 1'b1;
          state_d       = ST_FIRE;
        end
      end

      ST_FIRE: begin
        event_valid_d = 1'b1;
        if (tick && (late_ticks_q != LATE_MAX)) begin
          late_ticks_d = late_ticks_q + LATE_W'(1);
        end
        // A pending event survives an enable drop; only acceptance ends FIRE.
        if (event_ready) begin
          event_valid_d = 1'b0;
          state_d       = enable ? ST_ARM : ST_IDLE;
        end
      end

      default: begin
        event_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      event_valid_q <= 1'b0;
      event_kind_q  <= EV_HUNGER;
      late_ticks_q  <= '0;
    end else begin
      state_q       <= state_d;
      event_valid_q <= event_valid_d;
      event_kind_q  <= event_kind_d;
      late_ticks_q  <= late_ticks_d;
    end
  end

  assign event_valid = event_valid_q;
  assign event_kind  = event_kind_q;
  assign wait_left   = cnt_count;
  assign late_ticks  = late_ticks_q;

endmodule

// File: tb/tb_event_scheduler.sv
// Scoreboard bench for event_scheduler (MIN_WAIT=4 and MIN_WAIT=8 instances).
module tb_event_scheduler;
  import tama_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] rand_in;
  logic       en4, en8, rdy4, rdy8;
  logic       v4, v8;
  logic [1:0] k4, k8;
  logic [8:0] w4, w8;
  logic [3:0] l4, l8;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;

  always #5 clk = ~clk;

  event_scheduler #(.MIN_WAIT(4), .RAND_MASK(8'h3F)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .enable(en4), .rand_in(rand_in),
    .event_valid(v4), .event_kind(k4), .event_ready(rdy4),
    .wait_left(w4), .late_ticks(l4)
  );

  event_scheduler #(.MIN_WAIT(8), .RAND_MASK(8'h3F)) dut8 (
    .clk(clk), .rst(rst), .tick(tick), .enable(en8), .rand_in(rand_in),
    .event_valid(v8), .event_kind(k8), .event_ready(rdy8),
    .wait_left(w8), .late_ticks(l8)
  );

  // Scoreboard: every handshake on dut4 must match the next expected kind.
  always @(negedge clk) begin
    if (!rst && v4 && rdy4) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_accept kind=%0d with empty queue", k4);
      end else begin
        mon_exp = exp_q.pop_front();
        if (k4 !== mon_exp) begin
          bad++;
          $display("FAIL sb_kind got=%0d want=%0d", k4, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    repeat (n) pulse_tick();
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1; tick = 1'b0; rand_in = 8'h00;
    en4 = 1'b0; en8 = 1'b0; rdy4 = 1'b0; rdy8 = 1'b0;
    step(); step();
    total++; if (v4 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", v4); end
    total++; if (k4 !== 2'd0) begin bad++; $display("FAIL rst_kind got=%0d want=0", k4); end
    total++; if (w4 !== 9'd0) begin bad++; $display("FAIL rst_wait got=%0d want=0", w4); end
    total++; if (l4 !== 4'd0) begin bad++; $display("FAIL rst_late got=%0d want=0", l4); end
    rst = 1'b0;
    step();
    rand_in = 8'hC5; en4 = 1'b1;
    step(); step();
    ticks(4);
    total++; if (w4 !== 9'd5) begin bad++; $display("FAIL rst_pre_wait got=%0d want=5", w4); end
    #2 rst = 1'b1;
    #1;
    total++; if (v4 !== 1'b0 || w4 !== 9'd0) begin
      bad++; $display("FAIL rst_async got valid=%0b wait=%0d want 0/0", v4, w4);
    end
    total++; if (dut4.state_q !== ST_IDLE) begin
      bad++; $display("FAIL rst_state got=%0d want=%0d", dut4.state_q, ST_IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b0; en4 = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick = 1'b1; step(); if (v4) seen = 1'b1;
      tick = 1'b0; step(); if (v4) seen = 1'b1;
    end
    total++; if (seen !== 1'b0 || w4 !== 9'd0) begin
      bad++; $display("FAIL rst_quiet got seen=%0b wait=%0d want 0/0", seen, w4);
    end
  endtask

  task automatic test_basic();
    rand_in = 8'hC5;
    exp_q.push_back(2'd3);
    en4 = 1'b1;
    step(); step();
    total++; if (w4 !== 9'd9) begin bad++; $display("FAIL basic_load got=%0d want=9", w4); end
    ticks(8);
    total++; if (v4 !== 1'b0 || w4 !== 9'd1) begin
      bad++; $display("FAIL basic_pre_fire got valid=%0b wait=%0d want 0/1", v4, w4);
    end
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (v4 !== 1'b1 || k4 !== 2'd3 || w4 !== 9'd0) begin
      bad++; $display("FAIL basic_fire got valid=%0b kind=%0d wait=%0d want 1/3/0", v4, k4, w4);
    end
    rdy4 = 1'b1; step(); rdy4 = 1'b0;
    total++; if (v4 !== 1'b0) begin bad++; $display("FAIL basic_drop got=%0b want=0", v4); end
    step();
    total++; if (w4 !== 9'd9) begin bad++; $display("FAIL basic_reload got=%0d want=9", w4); end
    en4 = 1'b0; step();
    total++; if (w4 !== 9'd0) begin bad++; $display("FAIL basic_stop got=%0d want=0", w4); end
    step();
  endtask

  task automatic test_mask();
    rand_in = 8'hFF; en8 = 1'b1;
    step(); step();
    total++; if (w8 !== 9'd71) begin bad++; $display("FAIL mask_ff got=%0d want=71", w8); end
    en8 = 1'b0; step();
    total++; if (w8 !== 9'd0) begin bad++; $display("FAIL mask_clear got=%0d want=0", w8); end
    rand_in = 8'h40; en8 = 1'b1;
    step(); step();
    total++; if (w8 !== 9'd8) begin bad++; $display("FAIL mask_40 got=%0d want=8", w8); end
    ticks(7);
    total++; if (v8 !== 1'b0) begin bad++; $display("FAIL mask_early got=%0b want=0", v8); end
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (v8 !== 1'b1 || k8 !== 2'd1) begin
      bad++; $display("FAIL mask_fire got valid=%0b kind=%0d want 1/1", v8, k8);
    end
    rdy8 = 1'b1; en8 = 1'b0; step(); rdy8 = 1'b0;
    step();
    total++; if (v8 !== 1'b0 || dut8.state_q !== ST_IDLE || w8 !== 9'd0) begin
      bad++; $display("FAIL mask_idle got valid=%0b state=%0d wait=%0d want 0/0/0", v8, dut8.state_q, w8);
    end
  endtask

  task automatic test_enable_drop();
    logic seen;
    rand_in = 8'hC5; en4 = 1'b1;
    step(); step();
    ticks(6);
    total++; if (w4 !== 9'd3) begin bad++; $display("FAIL drop_pre got=%0d want=3", w4); end
    tick = 1'b1; en4 = 1'b0; step(); tick = 1'b0;
    total++; if (w4 !== 9'd0 || v4 !== 1'b0 || dut4.state_q !== ST_IDLE) begin
      bad++; $display("FAIL drop_wait got wait=%0d valid=%0b state=%0d want 0/0/0", w4, v4, dut4.state_q);
    end
    seen = 1'b0;
    repeat (20) begin
      pulse_tick(); if (v4) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL drop_quiet got=%0b want=0", seen); end
    rand_in = 8'h80;
    exp_q.push_back(2'd2);
    en4 = 1'b1;
    step(); step();
    ticks(3);
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (v4 !== 1'b1) begin bad++; $display("FAIL drop_fire got=%0b want=1", v4); end
    en4 = 1'b0;
    repeat (5) step();
    total++; if (v4 !== 1'b1 || k4 !== 2'd2) begin
      bad++; $display("FAIL drop_hold got valid=%0b kind=%0d want 1/2", v4, k4);
    end
    rdy4 = 1'b1; step(); rdy4 = 1'b0;
    total++; if (v4 !== 1'b0) begin bad++; $display("FAIL drop_accept got=%0b want=0", v4); end
    step();
    total++; if (dut4.state_q !== ST_IDLE || w4 !== 9'd0) begin
      bad++; $display("FAIL drop_idle got state=%0d wait=%0d want 0/0", dut4.state_q, w4);
    end
  endtask

  task automatic test_backpressure();
    rand_in = 8'hC5;
    exp_q.push_back(2'd3);
    en4 = 1'b1;
    step(); step();
    ticks(9);
    total++; if (v4 !== 1'b1 || l4 !== 4'd0) begin
      bad++; $display("FAIL bp_fire got valid=%0b late=%0d want 1/0", v4, l4);
    end
    rand_in = 8'h00;
    ticks(5);
    total++; if (l4 !== 4'd5) begin bad++; $display("FAIL bp_late5 got=%0d want=5", l4); end
    ticks(15);
    total++; if (l4 !== 4'd15 || v4 !== 1'b1 || k4 !== 2'd3) begin
      bad++; $display("FAIL bp_sat got late=%0d valid=%0b kind=%0d want 15/1/3", l4, v4, k4);
    end
    rand_in = 8'hC5;
    rdy4 = 1'b1; step(); rdy4 = 1'b0;
    total++; if (l4 !== 4'd15 || v4 !== 1'b0) begin
      bad++; $display("FAIL bp_accept got late=%0d valid=%0b want 15/0", l4, v4);
    end
    step();
    total++; if (l4 !== 4'd0 || w4 !== 9'd9) begin
      bad++; $display("FAIL bp_rearm got late=%0d wait=%0d want 0/9", l4, w4);
    end
    en4 = 1'b0; step(); step();
  endtask

  task automatic test_back_to_back();
    int pulses;
    int last_rise;
    logic prev;
    rdy4 = 1'b1; rand_in = 8'h40;
    step(); step();
    repeat (3) exp_q.push_back(2'd1);
    en4 = 1'b1; tick = 1'b1;
    pulses = 0; last_rise = -1; prev = 1'b0;
    for (int c = 0; c < 60 && pulses < 3; c++) begin
      step();
      if (v4 && prev) begin
        total++; bad++; $display("FAIL b2b_width valid held >1 clk at cycle %0d", c);
      end
      if (v4 && !prev) begin
        pulses++;
        if (last_rise >= 0) begin
          total++;
          if (c - last_rise !== 6) begin
            bad++; $display("FAIL b2b_spacing got=%0d want=6", c - last_rise);
          end
        end
        last_rise = c;
        if (pulses == 3) en4 = 1'b0;
      end
      prev = v4;
    end
    step();
    tick = 1'b0;
    total++; if (pulses !== 3 || v4 !== 1'b0) begin
      bad++; $display("FAIL b2b_count got pulses=%0d valid=%0b want 3/0", pulses, v4);
    end
    rdy4 = 1'b0;
    step();
    total++; if (dut4.state_q !== ST_IDLE) begin
      bad++; $display("FAIL b2b_idle got=%0d want=%0d", dut4.state_q, ST_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_enable_drop();
    test_backpressure();
    test_back_to_back();
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_scheduler.md
# event_scheduler

Downstream consumer of the 8-bit LFSR random stream. Turns pseudo-random bytes into timed pet events (hunger, boredom, sickness, sleepiness): it draws a random wait, counts it down in game ticks, then offers one event to the pet-state logic over a valid/ready handshake. It sits between the random source and the pet status/animation controller.

## Interface
- MIN_WAIT, 8, minimum wait in ticks; legal range 1..255
- RAND_MASK, 8'h3F, mask applied to the random byte to form the extra wait
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- tick  input  1  one-clk game-time strobe
- enable  input  1  scheduler run enable, level
- rand_in  input  8  pseudo-random byte, may change every clk
- event_valid  output  1  event offered
- event_kind  output  2  0 HUNGER, 1 BORED, 2 SICK, 3 SLEEPY; stable while event_valid
- event_ready  input  1  consumer accepts event
- wait_left  output  9  remaining ticks in current wait, 0 when not waiting
- late_ticks  output  4  ticks elapsed while an event waits unaccepted, saturating

## Operation
- States: IDLE, ARM, WAIT, FIRE. Reset: IDLE; event_valid 0, event_kind 0, wait_left 0, late_ticks 0.
- IDLE: enable=1 -> ARM.
- ARM (exactly one clk): wait_left <= MIN_WAIT + (rand_in & RAND_MASK), zero-extended to 9 bits; late_ticks <= 0; -> WAIT. enable=0 -> IDLE, nothing loaded.
- WAIT: each tick decrements wait_left. Tick with wait_left==1: wait_left <= 0, event_kind <= rand_in[7:6] (value present that clk), -> FIRE. enable=0 (also with simultaneous tick) -> IDLE, wait_left <= 0; enable wins.
- FIRE: event_valid=1. Each tick increments late_ticks, saturating at 15. event_valid & event_ready in same clk = accept: -> ARM if enable=1, else IDLE. enable drop does not withdraw a pending event; FIRE holds until accepted.
- event_ready while event_valid=0 is ignored.
- Width rule: MIN_WAIT + RAND_MASK <= 510; wait_left never loads 0, never wraps.

## Timing
- enable rise seen at edge k: ARM in cycle k+1, WAIT from k+2. Ticks during IDLE/ARM are ignored.
- With load N, event_valid asserts in the clk after the edge sampling the Nth WAIT tick.
- Back-to-back: accept at edge m -> ARM cycle m+1 -> new wait counted from m+2. Minimum event spacing is MIN_WAIT ticks + 2 clk.
- event_kind and event_valid are registered; no combinational path from any input to outputs.
- rst asserted in any state: outputs go to reset values immediately, including mid-FIRE (pending event dropped).

## Structure
- Shared package tama_pkg: typedef for event kind (HUNGER, BORED, SICK, SLEEPY, 2 bits), scheduler state enum, and the event-kind constants used by the pet controller.
- One sub-module: sched_countdown — 9-bit loadable down-counter with tick enable, clear, and terminal flag (count==1 & tick). FSM, kind latch and late counter stay in event_scheduler.

## Test plan
- Reset: rst pulse mid-WAIT with wait_left=5 -> event_valid 0, wait_left 0, state IDLE on the same edge; no event after 20 ticks with enable=0.
- Basic event: MIN_WAIT=4, RAND_MASK=8'h3F, rand_in held 8'hC5, enable=1 -> wait_left loads 9; event_valid rises after the 9th tick, event_kind=3; ready 1 clk later -> valid drops, wait_left reloads 9.
- Mask/range: rand_in=8'hFF, MIN_WAIT=8 -> wait_left=71; rand_in=8'h40 -> wait_left=8, event_kind=1.
- Enable drop: enable=0 in the same clk as a tick at wait_left=3 -> IDLE, wait_left 0, no event. Enable=0 during FIRE -> valid held until ready, then IDLE.
- Backpressure: event_ready held 0 for 20 ticks in FIRE -> event_valid stays 1, event_kind unchanged, late_ticks saturates at 15; on accept it is cleared at next ARM.
- Stray ready: event_ready=1 continuously from reset -> each event is valid for exactly 1 clk; no acceptance recorded while valid=0.
